// File: rtl/bcd_tick_counter_if.sv
// Control/status bundle between the BCD tick counter and its driver.
// up_dn exists only when BCD_CNT_DOWN_EN is defined.
interface bcd_tick_counter_if;
  logic       en;
  logic       load;
  logic [3:0] load_val;
`ifdef BCD_CNT_DOWN_EN
  logic       up_dn;
`endif
  logic [3:0] bcd;
  logic       tick;
  logic       carry;

  modport master (
`ifdef BCD_CNT_DOWN_EN
    output up_dn,
`endif
    output en, load, load_val,
    input  bcd, tick, carry
  );

  modport slave (
`ifdef BCD_CNT_DOWN_EN
    input  up_dn,
`endif
    input  en, load, load_val,
    output bcd, tick, carry
  );
endinterface

// File: rtl/bcd_tick_counter.sv
// Prescaled single-digit BCD counter; tick/carry registered with the digit, step every PRESC_MAX+1 enabled cycles.
// No backpressure: en freezes state, load always wins over count. Down counting via BCD_CNT_DOWN_EN.
module bcd_tick_counter #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int PW      = 32
) (
  input  logic                clk50MHz,
  input  logic                rst,
  bcd_tick_counter_if.slave   cnt
);

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ / TICK_HZ - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    bcd_q, bcd_d;
  logic          tick_q, tick_d;
  logic          carry_q, carry_d;
  logic          count_up;

`ifdef BCD_CNT_DOWN_EN
  assign count_up = cnt.up_dn;
`else
  assign count_up = 1'b1;
`endif

  always_comb begin
    presc_d = presc_q;
    bcd_d   = bcd_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    if (cnt.load) begin
      // Out-of-range BCD loads saturate so bcd never leaves 0..9.
      bcd_d   = (cnt.load_val > 4'd9) ? 4'd9 : cnt.load_val;
      presc_d = '0;
    end else if (cnt.en) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (count_up) begin
          if (bcd_q == 4'd9) begin
            bcd_d   = 4'd0;
            carry_d = 1'b1;
          end else begin
            bcd_d = bcd_q + 4'd1;
          end
        end else begin
          if (bcd_q == 4'd0) begin
            bcd_d   = 4'd9;
            carry_d = 1'b1;
          end else begin
            bcd_d = bcd_q - 4'd1;
          end
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      presc_q <= '0;
      bcd_q   <= 4'd0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      bcd_q   <= bcd_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  assign cnt.bcd   = bcd_q;
  assign cnt.tick  = tick_q;
  assign cnt.carry = carry_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench for bcd_tick_counter with PRESC_MAX=9 (step every 10 enabled cycles).
module tb_bcd_tick_counter;
  localparam int PM = 9;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bcd_tick_counter_if u_if();

  bcd_tick_counter #(.CLK_HZ(10), .TICK_HZ(1), .PW(8)) dut (
    .clk50MHz (clk),
    .rst      (rst),
    .cnt      (u_if)
  );

  always #5 clk = ~clk;

  // Reference state: cycles elapsed in the current period and the digit value.
  int m_presc = 0;
  int m_bcd   = 0;
  int m_tick  = 0;
  int m_carry = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] lv;
    int         e_bcd;
    int         e_tick;
    int         e_carry;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit up;
`ifdef BCD_CNT_DOWN_EN
    up = u_if.up_dn;
`else
    up = 1'b1;
`endif
    m_tick  = 0;
    m_carry = 0;
    if (rst) begin
      m_presc = 0;
      m_bcd   = 0;
    end else if (u_if.load) begin
      m_bcd   = (u_if.load_val > 9) ? 9 : int'(u_if.load_val);
      m_presc = 0;
    end else if (u_if.en) begin
      if (m_presc == PM) begin
        m_presc = 0;
        m_tick  = 1;
        if (up) begin
          m_carry = (m_bcd == 9);
          m_bcd   = (m_bcd + 1) % 10;
        end else begin
          m_carry = (m_bcd == 0);
          m_bcd   = (m_bcd + 9) % 10;
        end
      end else begin
        m_presc = m_presc + 1;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("bcd", int'(u_if.bcd), m_bcd);
    check("tick", int'(u_if.tick), m_tick);
    check("carry", int'(u_if.carry), m_carry);
  endtask

  task automatic run_until_tick(input int max, output int n);
    n = 0;
    for (int k = 0; k < max; k++) begin
      cycle();
      n++;
      if (u_if.tick === 1'b1) return;
    end
    check("tick timeout", 0, 1);
  endtask

  vec_t vecs[9];

  initial begin
    int n, ticks, carries, gap_bad, last, held, prev_tick;

    vecs[0] = '{1'b0, 1'b1, 1'b1, 4'd4,  4, 0, 0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 4'd12, 9, 0, 0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 4'd15, 9, 0, 0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 4'd0,  0, 0, 0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 4'd10, 9, 0, 0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 4'd9,  9, 0, 0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 4'd6,  0, 0, 0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 4'd3,  3, 0, 0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 4'd7,  3, 0, 0};

    rst = 1'b1;
    u_if.en = 1'b1;
    u_if.load = 1'b0;
    u_if.load_val = 4'd0;
`ifdef BCD_CNT_DOWN_EN
    u_if.up_dn = 1'b1;
`endif

    // Reset held for three edges, then first step ten edges later.
    repeat (3) cycle();
    check("reset bcd", int'(u_if.bcd), 0);
    check("reset tick", int'(u_if.tick), 0);
    rst = 1'b0;
    run_until_tick(20, n);
    check("first tick latency", n, 10);
    check("first tick bcd", int'(u_if.bcd), 1);

    // Free run: ten ticks, evenly spaced, one wrap carry.
    ticks = 0; carries = 0; gap_bad = 0; last = -1;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (u_if.tick) begin
        if (last >= 0 && i - last != 10) gap_bad++;
        last = i;
        ticks++;
      end
      if (u_if.carry) begin
        carries++;
        check("carry on wrap to 0", int'(u_if.bcd), 0);
      end
    end
    check("free run ticks", ticks, 10);
    check("free run spacing errors", gap_bad, 0);
    check("free run carries", carries, 1);
    check("free run end bcd", int'(u_if.bcd), 1);

    // Enable gating at presc=5 keeps the partial period.
    repeat (5) cycle();
    held = int'(u_if.bcd);
    u_if.en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      check("gated bcd hold", int'(u_if.bcd), held);
      check("gated tick", int'(u_if.tick), 0);
    end
    u_if.en = 1'b1;
    run_until_tick(20, n);
    check("resume latency", n, 5);

    // Load vectors.
    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst;
      u_if.en = vecs[i].en;
      u_if.load = vecs[i].load;
      u_if.load_val = vecs[i].lv;
      cycle();
      check($sformatf("vec%0d bcd", i), int'(u_if.bcd), vecs[i].e_bcd);
      check($sformatf("vec%0d tick", i), int'(u_if.tick), vecs[i].e_tick);
      check($sformatf("vec%0d carry", i), int'(u_if.carry), vecs[i].e_carry);
    end
    rst = 1'b0;
    u_if.load = 1'b0;
    u_if.en = 1'b1;
    run_until_tick(20, n);
    check("post-load latency", n, 10);
    check("post-load bcd", int'(u_if.bcd), 4);

    // Load in the terminal-count cycle while the digit is 9.
    u_if.load = 1'b1; u_if.load_val = 4'd9;
    cycle();
    u_if.load = 1'b0;
    repeat (9) cycle();
    u_if.load = 1'b1; u_if.load_val = 4'd2;
    cycle();
    check("tc load bcd", int'(u_if.bcd), 2);
    check("tc load tick", int'(u_if.tick), 0);
    check("tc load carry", int'(u_if.carry), 0);
    u_if.load = 1'b0;
    run_until_tick(20, n);
    check("tc load next latency", n, 10);
    check("tc load next bcd", int'(u_if.bcd), 3);

    // Reset mid-count with load and en asserted.
    u_if.load = 1'b1; u_if.load_val = 4'd7;
    cycle();
    u_if.load = 1'b0;
    repeat (8) cycle();
    rst = 1'b1; u_if.load = 1'b1; u_if.load_val = 4'd5;
    cycle();
    check("mid reset bcd", int'(u_if.bcd), 0);
    check("mid reset tick", int'(u_if.tick), 0);
    rst = 1'b0; u_if.load = 1'b0;
    run_until_tick(20, n);
    check("mid reset latency", n, 10);
    check("mid reset bcd after", int'(u_if.bcd), 1);

`ifdef BCD_CNT_DOWN_EN
    // Down count with borrow on 0 -> 9.
    u_if.load = 1'b1; u_if.load_val = 4'd1; u_if.up_dn = 1'b0;
    cycle();
    u_if.load = 1'b0;
    run_until_tick(20, n);
    check("down 1->0 bcd", int'(u_if.bcd), 0);
    check("down 1->0 carry", int'(u_if.carry), 0);
    run_until_tick(20, n);
    check("down 0->9 bcd", int'(u_if.bcd), 9);
    check("down 0->9 carry", int'(u_if.carry), 1);
    run_until_tick(20, n);
    check("down 9->8 bcd", int'(u_if.bcd), 8);
    check("down 9->8 carry", int'(u_if.carry), 0);
`endif

    // Randomized traffic against the reference model.
    prev_tick = int'(u_if.tick);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      u_if.load = ($urandom_range(0, 29) == 0);
      u_if.en = ($urandom_range(0, 3) != 0);
      u_if.load_val = 4'($urandom_range(0, 15));
`ifdef BCD_CNT_DOWN_EN
      u_if.up_dn = 1'($urandom_range(0, 1));
`endif
      cycle();
      check("bcd range", int'(u_if.bcd <= 4'd9), 1);
      check("tick back-to-back", prev_tick & int'(u_if.tick), 0);
      prev_tick = int'(u_if.tick);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
